// File: rtl/awgn_pkg.sv
// Shared widths for the AWGN generator datapath (normalizer and log stage).
// The module parameters default to these values.
package awgn_pkg;
  localparam int DATA_W_DEF   = 48;
  localparam int EXP_W_DEF    = 6;
  // Leading-zero count reported for an all-zero sample.
  localparam int LZC_ZERO_CNT = DATA_W_DEF;
endpackage

// File: rtl/lzc_prio.sv
// Combinational leading-zero counter built as a priority encoder.
// Returns DATA_W when the input is all zeros.
module lzc_prio
  import awgn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic [DATA_W-1:0] data,
  output logic [EXP_W-1:0]  count
);

  // Scan from the LSB upward so that the highest set bit determines the count.
  always_comb begin
    count = EXP_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) begin
        count = EXP_W'(DATA_W - 1 - i);
      end else begin
        count = count;
      end
    end
  end

endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage normalizer: stage 1 registers the sample and its leading-zero
// count, stage 2 registers the left-shifted mantissa for the log stage.
module norm_shift_pipe
  import awgn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero
);

  logic              en_s;
  logic [EXP_W-1:0]  lzc_s;
  logic [DATA_W-1:0] s1_data_r;
  logic [EXP_W-1:0]  s1_cnt_r;
  logic              s1_valid_r;

  // A single enable advances both stages, so a full output stalls everything.
  assign en_s     = !out_valid | out_ready;
  assign in_ready = en_s;

  lzc_prio #(
    .DATA_W (DATA_W),
    .EXP_W  (EXP_W)
  ) u_lzc (
    .data  (in_data),
    .count (lzc_s)
  );

  // Stage 1: capture sample, valid and leading-zero count.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_data_r  <= '0;
      s1_cnt_r   <= '0;
      s1_valid_r <= 1'b0;
    end else if (en_s) begin
      s1_data_r  <= in_data;
      s1_cnt_r   <= lzc_s;
      s1_valid_r <= in_valid;
    end else begin
      s1_data_r  <= s1_data_r;
      s1_cnt_r   <= s1_cnt_r;
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: normalize; a shift by DATA_W yields zero for the all-zero sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_mant  <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en_s) begin
      out_mant  <= s1_data_r << s1_cnt_r;
      out_exp   <= s1_cnt_r;
      out_zero  <= (s1_cnt_r == EXP_W'(DATA_W));
      out_valid <= s1_valid_r;
    end else begin
      out_mant  <= out_mant;
      out_exp   <= out_exp;
      out_zero  <= out_zero;
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Self-checking bench for norm_shift_pipe: directed cases plus random traffic
// scored against an in-order queue of arithmetically computed results.
module tb_norm_shift_pipe;
  localparam int DW = 48;
  localparam int EW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_zero;

  norm_shift_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] mant;
    int            lz;
    logic          zero;
    int            acc_cyc;
    int            acc_stall;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   stall_cnt  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: count zeros from the MSB down; mantissa is the sample scaled by 2^lz.
  function automatic exp_t model(input logic [DW-1:0] d);
    exp_t e;
    int   n = 0;
    while (n < DW && d[DW-1-n] == 1'b0) n++;
    e.data = d;
    e.lz   = n;
    e.mant = (n == DW) ? '0 : (d << n);
    e.zero = (d == '0);
    e.acc_cyc = 0;
    e.acc_stall = 0;
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, score, advance.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic orr);
    logic          fire, acc, stall, pv, pz;
    logic [DW-1:0] pm;
    logic [EW-1:0] pe;
    exp_t          e;
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    #1;
    chk("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid) | orr});
    fire  = out_valid && orr;
    acc   = iv && in_ready;
    stall = out_valid && !orr;
    if (fire) begin
      if (q.size() == 0) begin
        chk("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("out_mant", {16'd0, out_mant}, {16'd0, e.mant});
        chk("out_exp", {58'd0, out_exp}, 64'(e.lz));
        chk("out_zero", {63'd0, out_zero}, {63'd0, e.zero});
        if (!e.zero) chk("exact", {16'd0, out_mant >> out_exp}, {16'd0, e.data});
        if (e.acc_stall == stall_cnt) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
      end
    end
    if (acc) begin
      e = model(d);
      e.acc_cyc = cyc;
      e.acc_stall = stall_cnt;
      q.push_back(e);
    end
    if (stall) stall_cnt++;
    pm = out_mant; pe = out_exp; pz = out_zero; pv = out_valid;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (stall) begin
      chk("hold_valid", {63'd0, out_valid}, {63'd0, pv});
      chk("hold_mant", {16'd0, out_mant}, {16'd0, pm});
      chk("hold_exp", {58'd0, out_exp}, {58'd0, pe});
      chk("hold_zero", {63'd0, out_zero}, {63'd0, pz});
    end
  endtask

  // Reset for one cycle with out_ready low so reset must beat the stall.
  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc++;
    q.delete();
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_mant", {16'd0, out_mant}, 64'd0);
    chk("rst_out_exp", {58'd0, out_exp}, 64'd0);
    chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, '0, 1'b1);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  logic [DW-1:0] rnd;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // MSB set, single LSB, mid pattern, zero.
    step(1'b1, 48'h800000000000, 1'b1);
    step(1'b0, 48'h0, 1'b1);
    step(1'b0, 48'h0, 1'b1);
    step(1'b1, 48'h000000000001, 1'b1);
    step(1'b1, 48'h00F000000000, 1'b1);
    step(1'b1, 48'h000000000000, 1'b1);
    drain();

    // Back-to-back throughput.
    step(1'b1, 48'h400000000000, 1'b1);
    step(1'b1, 48'h000010000000, 1'b1);
    step(1'b1, 48'h000000000003, 1'b1);
    drain();

    // Stream of four with a three-cycle stall after the first output.
    step(1'b1, 48'h123456789ABC, 1'b1);
    step(1'b1, 48'h000ABCDEF012, 1'b1);
    step(1'b1, 48'h000000F00000, 1'b1);
    step(1'b1, 48'h000000000000, 1'b0);
    step(1'b1, 48'h000000000000, 1'b0);
    step(1'b1, 48'h000000000000, 1'b0);
    step(1'b1, 48'h7FFFFFFFFFFF, 1'b1);
    drain();

    // Reset with two samples in flight; nothing may appear afterwards.
    step(1'b1, 48'h0000FFFF0000, 1'b1);
    step(1'b1, 48'h00000000FFFF, 1'b1);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    // Random traffic with random leading-zero depth and backpressure.
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom};
      rnd = rnd >> $urandom_range(0, DW);
      step(1'($urandom_range(0, 3) != 0), rnd, 1'($urandom_range(0, 2) != 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/norm_shift_pipe.md
NORM_SHIFT_PIPE -- requirements
Module: norm_shift_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 48, input/mantissa width.
REQ-002 SHALL have parameter EXP_W, default 6, leading-zero/exponent width; EXP_W SHALL satisfy 2^EXP_W > DATA_W.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_data is offered this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  unsigned fraction 0.in_data; the uniform sample for the log stage.
REQ-008 SHALL have port out_valid  output  1  out_mant/out_exp/out_zero are valid.
REQ-009 SHALL have port out_ready  input  1  downstream log stage accepts the result this cycle.
REQ-010 SHALL have port out_mant  output  DATA_W  normalized mantissa; MSB = 1 unless out_zero.
REQ-011 SHALL have port out_exp  output  EXP_W  leading-zero count of the accepted in_data.
REQ-012 SHALL have port out_zero  output  1  accepted in_data was all zeros.

Function
REQ-013 SHALL accept a sample on any cycle where in_valid and in_ready are both 1; SHALL pass a result on any cycle where out_valid and out_ready are both 1.
REQ-014 SHALL be a two-register pipeline under one global enable en = !out_valid | out_ready; in_ready SHALL equal en.
REQ-015 Stage 1 (when en): SHALL register in_data, in_valid, and the leading-zero count of in_data (0..DATA_W-1, DATA_W for zero input).
REQ-016 Stage 2 (when en): SHALL register out_mant = stage-1 data << count (zero-fill), out_exp = count, out_zero = (count == DATA_W), out_valid = stage-1 valid.
REQ-017 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held 1; throughput SHALL be one sample per cycle.
REQ-018 Result SHALL satisfy 0.in_data = 0.out_mant * 2^-out_exp exactly; no bits lost.
REQ-019 Zero input: out_exp SHALL be DATA_W (48), out_mant SHALL be 0, out_zero SHALL be 1.
REQ-020 in_data with MSB set: out_exp SHALL be 0, out_mant SHALL equal in_data.
REQ-021 Stall (out_valid=1, out_ready=0): both stages, out_* and in_ready SHALL hold; in_ready SHALL be 0; no sample dropped or duplicated.
REQ-022 Bubbles (in_valid=0 on an accepted cycle) SHALL propagate as invalid slots; out_mant/out_exp/out_zero are don't-care while out_valid=0.
REQ-023 Samples SHALL leave in acceptance order.

Reset
REQ-024 reset SHALL be sampled on clk only and SHALL override en.
REQ-025 During/after reset: out_valid=0, stage-1 valid=0, out_mant=0, out_exp=0, out_zero=0; in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-026 Reset mid-operation SHALL discard all in-flight samples; none SHALL appear at the output afterwards.

Structure
REQ-027 DATA_W/EXP_W defaults and the zero-count constant (DATA_W) SHALL reside in a shared package awgn_pkg used by the log stage.
REQ-028 Leading-zero count SHALL be a combinational sub-module lzc_prio (priority encoder, DATA_W in, EXP_W out, DATA_W for all-zero); shifter and pipeline registers SHALL be in norm_shift_pipe.

Verification
REQ-029 Reset, then in_data=0x800000000000 with out_ready=1 -> two cycles later out_valid=1, out_exp=0, out_mant=0x800000000000, out_zero=0.
REQ-030 in_data=0x000000000001 -> out_exp=47, out_mant=0x800000000000; in_data=0x00F000000000 -> out_exp=8, out_mant=0xF00000000000.
REQ-031 in_data=0 -> out_exp=48, out_mant=0, out_zero=1.
REQ-032 Back-to-back 0x400000000000, 0x000010000000, 0x3 with out_ready=1 -> consecutive outputs exp 1, 19, 46, in order, no gaps.
REQ-033 Stream 4 samples, drop out_ready for 3 cycles after first output -> in_ready=0 and outputs frozen during stall; all 4 results delivered once, in order.
REQ-034 Assert reset for 1 cycle with two samples in flight -> out_valid=0 next cycle and neither sample ever emitted.
